// File: rtl/rv32i_memoryaccess_stage.sv
// RV32I stage 4: runs LOAD/STORE on a req/ack data port, aligns/extends load
// data and produces the stage-5 result bundle plus the memory-busy stall.
`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 11
`endif
`ifndef LOAD
`define LOAD 2
`endif
`ifndef STORE
`define STORE 3
`endif

module rv32i_memoryaccess_stage #(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_ce,
    input  logic                     i_stall,
    output logic                     o_stall,
    input  logic [`OPCODE_WIDTH-1:0] i_opcode,
    input  logic [2:0]               i_funct3,
    input  logic [4:0]               i_rd_addr,
    input  logic                     i_wr_rd,
    input  logic [31:0]              i_rd,
    input  logic [31:0]              i_rs2_store,
    output logic [4:0]               o_memoryaccess_rd_addr,
    output logic                     o_memoryaccess_wr_rd,
    output logic [31:0]              o_writeback_rd,
    output logic                     o_writeback_ce,
    output logic                     o_dmem_req,
    output logic                     o_dmem_we,
    output logic [31:0]              o_dmem_addr,
    output logic [31:0]              o_dmem_wdata,
    output logic [3:0]               o_dmem_wsel,
    input  logic                     i_dmem_ack,
    input  logic [31:0]              i_dmem_rdata,
    output logic                     o_misaligned,
    output logic                     o_bus_err
);
    typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

    state_t      state_q, state_d;
    logic [9:0]  cnt_q, cnt_d;
    logic        req_q, req_d, we_q, we_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
    logic [3:0]  wsel_q, wsel_d;
    logic        wb_ce_q, wb_ce_d;
    logic [31:0] rd_q, rd_d;
    logic [4:0]  rd_addr_q, rd_addr_d;
    logic        wr_rd_q, wr_rd_d, mis_q, mis_d, berr_q, berr_d;
    // Pending-access context, kept apart so the forwarding outputs stay stable
    // while a memory access is in flight.
    logic [4:0]  p_rd_addr_q, p_rd_addr_d;
    logic        p_wr_rd_q, p_wr_rd_d, p_load_q, p_load_d;
    logic [2:0]  p_f3_q, p_f3_d;
    logic [1:0]  p_off_q, p_off_d;
    logic [31:0] buf_q, buf_d;

    logic        is_load, is_store, misaligned;
    logic [31:0] sh, ld_val, st_wdata;
    logic [3:0]  st_wsel;
    logic        unused_opcode;

    assign is_load       = i_opcode[`LOAD];
    assign is_store      = i_opcode[`STORE];
    assign unused_opcode = ^i_opcode;
    assign misaligned    = (i_funct3[1:0] == 2'b01 && i_rd[0]) ||
                           (i_funct3[1] && i_rd[1:0] != 2'b00);

    always_comb begin
        st_wdata = i_rs2_store;
        st_wsel  = 4'b1111;
        if (i_funct3[1:0] == 2'b00) begin
            st_wdata = {4{i_rs2_store[7:0]}};
            st_wsel  = 4'b0001 << i_rd[1:0];
        end else if (i_funct3[1:0] == 2'b01) begin
            st_wdata = {2{i_rs2_store[15:0]}};
            st_wsel  = i_rd[1] ? 4'b1100 : 4'b0011;
        end
        if (!is_store) st_wsel = 4'b1111;
    end

    always_comb begin
        sh = i_dmem_rdata >> {p_off_q, 3'b000};
        case (p_f3_q)
            3'b000:  ld_val = {{24{sh[7]}}, sh[7:0]};
            3'b001:  ld_val = {{16{sh[15]}}, sh[15:0]};
            3'b100:  ld_val = {24'd0, sh[7:0]};
            3'b101:  ld_val = {16'd0, sh[15:0]};
            default: ld_val = i_dmem_rdata;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_d       = req_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wsel_d      = wsel_q;
        wb_ce_d     = wb_ce_q;
        rd_d        = rd_q;
        rd_addr_d   = rd_addr_q;
        wr_rd_d     = wr_rd_q;
        mis_d       = mis_q;
        berr_d      = berr_q;
        p_rd_addr_d = p_rd_addr_q;
        p_wr_rd_d   = p_wr_rd_q;
        p_load_d    = p_load_q;
        p_f3_d      = p_f3_q;
        p_off_d     = p_off_q;
        buf_d       = buf_q;
        case (state_q)
            IDLE: if (!i_stall) begin
                wb_ce_d = 1'b0;
                mis_d   = 1'b0;
                berr_d  = 1'b0;
                if (i_ce) begin
                    if (!(is_load || is_store)) begin
                        wb_ce_d   = 1'b1;
                        rd_d      = i_rd;
                        rd_addr_d = i_rd_addr;
                        wr_rd_d   = i_wr_rd;
                    end else if (misaligned) begin
                        wb_ce_d   = 1'b1;
                        mis_d     = 1'b1;
                        rd_d      = i_rd;
                        rd_addr_d = i_rd_addr;
                        wr_rd_d   = 1'b0;
                    end else begin
                        req_d       = 1'b1;
                        we_d        = is_store;
                        addr_d      = {i_rd[31:2], 2'b00};
                        wdata_d     = st_wdata;
                        wsel_d      = st_wsel;
                        p_rd_addr_d = i_rd_addr;
                        p_wr_rd_d   = i_wr_rd;
                        p_load_d    = is_load;
                        p_f3_d      = i_funct3;
                        p_off_d     = i_rd[1:0];
                        cnt_d       = '0;
                        state_d     = WAIT;
                    end
                end
            end
            WAIT: begin
                // Ack beats a coinciding timeout.
                if (i_dmem_ack) begin
                    req_d = 1'b0;
                    cnt_d = '0;
                    if (i_stall) begin
                        buf_d   = ld_val;
                        state_d = HOLD;
                    end else begin
                        wb_ce_d   = 1'b1;
                        rd_d      = ld_val;
                        rd_addr_d = p_rd_addr_q;
                        wr_rd_d   = p_wr_rd_q & p_load_q;
                        state_d   = IDLE;
                    end
                end else if (cnt_q == 10'(ACK_TIMEOUT - 1)) begin
                    req_d     = 1'b0;
                    cnt_d     = '0;
                    berr_d    = 1'b1;
                    wb_ce_d   = 1'b1;
                    rd_addr_d = p_rd_addr_q;
                    wr_rd_d   = 1'b0;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
            end
            HOLD: if (!i_stall) begin
                wb_ce_d   = 1'b1;
                rd_d      = buf_q;
                rd_addr_d = p_rd_addr_q;
                wr_rd_d   = p_wr_rd_q & p_load_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wsel_q      <= '0;
            wb_ce_q     <= 1'b0;
            rd_q        <= '0;
            rd_addr_q   <= '0;
            wr_rd_q     <= 1'b0;
            mis_q       <= 1'b0;
            berr_q      <= 1'b0;
            p_rd_addr_q <= '0;
            p_wr_rd_q   <= 1'b0;
            p_load_q    <= 1'b0;
            p_f3_q      <= '0;
            p_off_q     <= '0;
            buf_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_q       <= req_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wsel_q      <= wsel_d;
            wb_ce_q     <= wb_ce_d;
            rd_q        <= rd_d;
            rd_addr_q   <= rd_addr_d;
            wr_rd_q     <= wr_rd_d;
            mis_q       <= mis_d;
            berr_q      <= berr_d;
            p_rd_addr_q <= p_rd_addr_d;
            p_wr_rd_q   <= p_wr_rd_d;
            p_load_q    <= p_load_d;
            p_f3_q      <= p_f3_d;
            p_off_q     <= p_off_d;
            buf_q       <= buf_d;
        end
    end

    assign o_stall                = (state_q != IDLE) | i_stall;
    assign o_dmem_req             = req_q;
    assign o_dmem_we              = we_q;
    assign o_dmem_addr            = addr_q;
    assign o_dmem_wdata           = wdata_q;
    assign o_dmem_wsel            = wsel_q;
    assign o_writeback_ce         = wb_ce_q;
    assign o_writeback_rd         = rd_q;
    assign o_memoryaccess_rd_addr = rd_addr_q;
    assign o_memoryaccess_wr_rd   = wr_rd_q;
    assign o_misaligned           = mis_q;
    assign o_bus_err              = berr_q;
endmodule

// File: tb/tb_rv32i_memoryaccess_stage.sv
// Scoreboard bench for rv32i_memoryaccess_stage: expected retirements are
// queued at issue and compared when o_writeback_ce is consumed downstream.
module tb_rv32i_memoryaccess_stage;
    localparam logic [`OPCODE_WIDTH-1:0] OP_ALU   = `OPCODE_WIDTH'(1);
    localparam logic [`OPCODE_WIDTH-1:0] OP_LOAD  = `OPCODE_WIDTH'(1) << `LOAD;
    localparam logic [`OPCODE_WIDTH-1:0] OP_STORE = `OPCODE_WIDTH'(1) << `STORE;

    logic i_clk = 1'b0, i_rst, i_ce, i_stall, o_stall;
    logic [`OPCODE_WIDTH-1:0] i_opcode;
    logic [2:0]  i_funct3;
    logic [4:0]  i_rd_addr, o_memoryaccess_rd_addr;
    logic        i_wr_rd, o_memoryaccess_wr_rd, o_writeback_ce;
    logic [31:0] i_rd, i_rs2_store, o_writeback_rd;
    logic        o_dmem_req, o_dmem_we, i_dmem_ack, o_misaligned, o_bus_err;
    logic [31:0] o_dmem_addr, o_dmem_wdata, i_dmem_rdata;
    logic [3:0]  o_dmem_wsel;

    typedef struct {
        logic [31:0] rd;
        logic [4:0]  rd_addr;
        logic        wr_rd, mis, berr, chk_rd;
    } wb_t;
    wb_t sb[$];
    wb_t mon_e;
    int n_chk = 0, n_err = 0;

    rv32i_memoryaccess_stage #(.ACK_TIMEOUT(4)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_ce(i_ce), .i_stall(i_stall), .o_stall(o_stall),
        .i_opcode(i_opcode), .i_funct3(i_funct3), .i_rd_addr(i_rd_addr), .i_wr_rd(i_wr_rd),
        .i_rd(i_rd), .i_rs2_store(i_rs2_store),
        .o_memoryaccess_rd_addr(o_memoryaccess_rd_addr), .o_memoryaccess_wr_rd(o_memoryaccess_wr_rd),
        .o_writeback_rd(o_writeback_rd), .o_writeback_ce(o_writeback_ce),
        .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we), .o_dmem_addr(o_dmem_addr),
        .o_dmem_wdata(o_dmem_wdata), .o_dmem_wsel(o_dmem_wsel), .i_dmem_ack(i_dmem_ack),
        .i_dmem_rdata(i_dmem_rdata), .o_misaligned(o_misaligned), .o_bus_err(o_bus_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic expect_wb(input logic [31:0] rd, input logic [4:0] ra, input logic wr,
                             input logic mis, input logic be, input logic crd);
        wb_t e;
        e.rd = rd; e.rd_addr = ra; e.wr_rd = wr; e.mis = mis; e.berr = be; e.chk_rd = crd;
        sb.push_back(e);
    endtask

    task automatic issue(input logic [`OPCODE_WIDTH-1:0] op, input logic [2:0] f3,
                         input logic [4:0] ra, input logic wr, input logic [31:0] a,
                         input logic [31:0] d);
        i_ce = 1'b1; i_opcode = op; i_funct3 = f3; i_rd_addr = ra; i_wr_rd = wr;
        i_rd = a; i_rs2_store = d;
        tick();
        i_ce = 1'b0;
    endtask

    // Drives the memory side while req is up; ack_at=0 means never ack.
    task automatic do_mem(input int ack_at, input logic [31:0] rdata, input int stall_n,
                          input int exp_n);
        int n = 0;
        while (o_dmem_req && n < 20) begin
            chk("stall_busy", 32'(o_stall), 32'd1);
            n++;
            if (n == ack_at) begin
                i_dmem_ack = 1'b1;
                i_dmem_rdata = rdata;
                if (stall_n > 0) i_stall = 1'b1;
            end
            tick();
            i_dmem_ack = 1'b0;
            i_dmem_rdata = 32'hDEAD_BEEF;
        end
        chk("req_cycles", 32'(n), 32'(exp_n));
        for (int k = 0; k < stall_n; k++) begin
            chk("hold_no_ce", 32'(o_writeback_ce), 32'd0);
            chk("hold_stall", 32'(o_stall), 32'd1);
            if (k == stall_n - 1) i_stall = 1'b0;
            tick();
        end
    endtask

    always @(negedge i_clk) begin
        if (!i_rst && o_writeback_ce && !i_stall) begin
            if (sb.size() == 0) chk("wb_unexpected", 32'd1, 32'd0);
            else begin
                mon_e = sb.pop_front();
                chk("wb_rd_addr", 32'(o_memoryaccess_rd_addr), 32'(mon_e.rd_addr));
                chk("wb_wr_rd", 32'(o_memoryaccess_wr_rd), 32'(mon_e.wr_rd));
                chk("wb_mis", 32'(o_misaligned), 32'(mon_e.mis));
                chk("wb_berr", 32'(o_bus_err), 32'(mon_e.berr));
                if (mon_e.chk_rd) chk("wb_rd", o_writeback_rd, mon_e.rd);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst = 1'b1; i_ce = 1'b0; i_stall = 1'b0; i_opcode = OP_ALU; i_funct3 = 3'b000;
        i_rd_addr = 5'd0; i_wr_rd = 1'b0; i_rd = 32'd0; i_rs2_store = 32'd0;
        i_dmem_ack = 1'b0; i_dmem_rdata = 32'hDEAD_BEEF;
        tick(); tick();
        chk("rst_req", 32'(o_dmem_req), 32'd0);
        chk("rst_ce", 32'(o_writeback_ce), 32'd0);
        chk("rst_rd", o_writeback_rd, 32'd0);
        chk("rst_wsel", 32'(o_dmem_wsel), 32'd0);
        chk("rst_flags", 32'({o_misaligned, o_bus_err, o_memoryaccess_wr_rd}), 32'd0);
        i_rst = 1'b0;
        tick();
        chk("idle_stall", 32'(o_stall), 32'd0);

        // ALU result passes through in one cycle.
        expect_wb(32'h0000_1234, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1);
        issue(OP_ALU, 3'b000, 5'd5, 1'b1, 32'h0000_1234, 32'd0);
        chk("alu_ce", 32'(o_writeback_ce), 32'd1);
        chk("alu_noreq", 32'(o_dmem_req), 32'd0);

        // LB / LBU at byte 3, ack on third request cycle.
        expect_wb(32'hFFFF_FF80, 5'd6, 1'b1, 1'b0, 1'b0, 1'b1);
        issue(OP_LOAD, 3'b000, 5'd6, 1'b1, 32'h0000_0103, 32'd0);
        chk("lb_addr", o_dmem_addr, 32'h0000_0100);
        chk("lb_we", 32'(o_dmem_we), 32'd0);
        chk("lb_wsel", 32'(o_dmem_wsel), 32'hF);
        do_mem(3, 32'h80FF_FF7F, 0, 3);
        expect_wb(32'h0000_0080, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1);
        issue(OP_LOAD, 3'b100, 5'd7, 1'b1, 32'h0000_0103, 32'd0);
        do_mem(3, 32'h80FF_FF7F, 0, 3);

        // LH upper half sign-extends, LW passes through.
        expect_wb(32'hFFFF_80FF, 5'd8, 1'b1, 1'b0, 1'b0, 1'b1);
        issue(OP_LOAD, 3'b001, 5'd8, 1'b1, 32'h0000_0102, 32'd0);
        do_mem(1, 32'h80FF_FF7F, 0, 1);
        expect_wb(32'hCAFE_F00D, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1);
        issue(OP_LOAD, 3'b010, 5'd9, 1'b1, 32'h0000_0300, 32'd0);
        do_mem(2, 32'hCAFE_F00D, 0, 2);

        // SH upper half and SB byte 1.
        expect_wb(32'd0, 5'd10, 1'b0, 1'b0, 1'b0, 1'b0);
        issue(OP_STORE, 3'b001, 5'd10, 1'b1, 32'h0000_0202, 32'hABCD_1234);
        chk("sh_wdata", o_dmem_wdata, 32'h1234_1234);
        chk("sh_wsel", 32'(o_dmem_wsel), 32'hC);
        chk("sh_we", 32'(o_dmem_we), 32'd1);
        chk("sh_addr", o_dmem_addr, 32'h0000_0200);
        do_mem(2, 32'd0, 0, 2);
        expect_wb(32'd0, 5'd11, 1'b0, 1'b0, 1'b0, 1'b0);
        issue(OP_STORE, 3'b000, 5'd11, 1'b0, 32'h0000_0201, 32'h1111_2255);
        chk("sb_wdata", o_dmem_wdata, 32'h5555_5555);
        chk("sb_wsel", 32'(o_dmem_wsel), 32'h2);
        do_mem(1, 32'd0, 0, 1);

        // Misaligned LW and SH: no request, flagged retirement.
        expect_wb(32'd0, 5'd12, 1'b0, 1'b1, 1'b0, 1'b0);
        issue(OP_LOAD, 3'b010, 5'd12, 1'b1, 32'h0000_0301, 32'd0);
        chk("mis_noreq", 32'(o_dmem_req), 32'd0);
        chk("mis_pulse", 32'(o_misaligned), 32'd1);
        expect_wb(32'd0, 5'd13, 1'b0, 1'b1, 1'b0, 1'b0);
        issue(OP_STORE, 3'b001, 5'd13, 1'b0, 32'h0000_0203, 32'd0);
        chk("mis2_noreq", 32'(o_dmem_req), 32'd0);
        tick();
        chk("mis_clear", 32'(o_misaligned), 32'd0);

        // Timeout, then ack exactly on the timeout cycle.
        expect_wb(32'd0, 5'd14, 1'b0, 1'b0, 1'b1, 1'b0);
        issue(OP_LOAD, 3'b010, 5'd14, 1'b1, 32'h0000_0500, 32'd0);
        do_mem(0, 32'd0, 0, 4);
        chk("to_berr", 32'(o_bus_err), 32'd1);
        chk("to_ce", 32'(o_writeback_ce), 32'd1);
        expect_wb(32'h0BAD_F00D, 5'd15, 1'b1, 1'b0, 1'b0, 1'b1);
        issue(OP_LOAD, 3'b010, 5'd15, 1'b1, 32'h0000_0504, 32'd0);
        chk("after_to_req", 32'(o_dmem_req), 32'd1);
        do_mem(4, 32'h0BAD_F00D, 0, 4);
        chk("ack_wins", 32'(o_bus_err), 32'd0);

        // LHU acked under downstream stall: buffered in HOLD for 2 cycles.
        expect_wb(32'h0000_8765, 5'd16, 1'b1, 1'b0, 1'b0, 1'b1);
        issue(OP_LOAD, 3'b101, 5'd16, 1'b1, 32'h0000_0400, 32'd0);
        do_mem(2, 32'h1234_8765, 2, 2);
        chk("hold_rel_ce", 32'(o_writeback_ce), 32'd1);

        // Stall in IDLE holds the retirement pulse.
        expect_wb(32'h0000_00AA, 5'd17, 1'b1, 1'b0, 1'b0, 1'b1);
        issue(OP_ALU, 3'b000, 5'd17, 1'b1, 32'h0000_00AA, 32'd0);
        i_stall = 1'b1;
        tick();
        chk("idle_hold_ce", 32'(o_writeback_ce), 32'd1);
        tick();
        chk("idle_hold_ce2", 32'(o_writeback_ce), 32'd1);
        i_stall = 1'b0;
        tick();
        chk("idle_rel_ce", 32'(o_writeback_ce), 32'd0);

        // Stray ack in IDLE is ignored.
        i_dmem_ack = 1'b1;
        tick();
        i_dmem_ack = 1'b0;
        chk("stray_ack_req", 32'(o_dmem_req), 32'd0);
        chk("stray_ack_ce", 32'(o_writeback_ce), 32'd0);

        // Reset during WAIT discards the access.
        issue(OP_LOAD, 3'b010, 5'd18, 1'b1, 32'h0000_0600, 32'd0);
        chk("rw_req", 32'(o_dmem_req), 32'd1);
        tick();
        i_rst = 1'b1;
        tick();
        chk("rw_req0", 32'(o_dmem_req), 32'd0);
        chk("rw_ce0", 32'(o_writeback_ce), 32'd0);
        i_rst = 1'b0;
        tick();
        chk("rw_ce1", 32'(o_writeback_ce), 32'd0);
        chk("rw_idle", 32'(o_stall), 32'd0);

        expect_wb(32'h0000_0042, 5'd19, 1'b1, 1'b0, 1'b0, 1'b1);
        issue(OP_ALU, 3'b000, 5'd19, 1'b1, 32'h0000_0042, 32'd0);
        tick(); tick();
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
